// File: rtl/adpcm_nibble_packer.sv
// ADPCM nibble packer: packs 4-bit IMA ADPCM codes into bytes (first code in
// the low nibble) and buffers them in a first-word-fall-through FIFO.
// Optional session header (8'hA5 then session count) under PACKER_HEADER_EN.
module adpcm_nibble_packer #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [3:0]  PAD_NIBBLE = 4'h0,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          block_enable,
  input  logic [3:0]    in_code,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  typedef enum logic {StEmpty, StHalf} pack_st_e;

  pack_st_e        pack_q, pack_d;
  logic [3:0]      lo_nib_q, lo_nib_d;
  logic            in_valid_q, en_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];

  logic            accept, sess_start, sess_end;
  logic            push, push_ok, pop, full;
  logic [7:0]      push_data;

`ifdef PACKER_HEADER_EN
  typedef enum logic [1:0] {HdrIdle, HdrMagic, HdrCount} hdr_st_e;
  hdr_st_e         hdr_q, hdr_d;
  logic [7:0]      sess_cnt_q, sess_cnt_d;
`endif

  // Edge-qualified capture, session edges and packer/header next state.
  always_comb begin
    accept     = in_valid & ~in_valid_q & block_enable;
    sess_start = block_enable & ~en_q;
    sess_end   = ~block_enable & en_q;
    pack_d     = pack_q;
    lo_nib_d   = lo_nib_q;
    push       = 1'b0;
    push_data  = 8'h00;

    if (sess_start) begin
      pack_d = StEmpty;
    end else if (sess_end) begin
      // Complete a dangling half byte with the pad code.
      if (pack_q == StHalf) begin
        push      = 1'b1;
        push_data = {PAD_NIBBLE, lo_nib_q};
        pack_d    = StEmpty;
      end
    end else if (accept) begin
      unique case (pack_q)
        StEmpty: begin
          lo_nib_d = in_code;
          pack_d   = StHalf;
        end
        StHalf: begin
          push      = 1'b1;
          push_data = {in_code, lo_nib_q};
          pack_d    = StEmpty;
        end
        default: pack_d = StEmpty;
      endcase
    end

`ifdef PACKER_HEADER_EN
    hdr_d      = hdr_q;
    sess_cnt_d = sess_cnt_q;
    // Header pushes land in start+1 and start+2; data cannot arrive before +3.
    unique case (hdr_q)
      HdrMagic: begin
        push      = 1'b1;
        push_data = 8'hA5;
        hdr_d     = HdrCount;
      end
      HdrCount: begin
        push       = 1'b1;
        push_data  = sess_cnt_q;
        sess_cnt_d = sess_cnt_q + 8'd1;
        hdr_d      = HdrIdle;
      end
      default: hdr_d = HdrIdle;
    endcase
    if (sess_start) hdr_d = HdrMagic;
`endif
  end

  // FIFO bookkeeping: a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    pop        = out_valid & out_ready;
    full       = (level_q == LW'(DEPTH));
    push_ok    = push & (~full | pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    overflow_d = overflow_q;
    if (sess_start) overflow_d = 1'b0;
    if (push & full & ~pop) overflow_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= StEmpty;
      lo_nib_q   <= 4'h0;
      in_valid_q <= 1'b0;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      lo_nib_q   <= lo_nib_d;
      in_valid_q <= in_valid;
      en_q       <= block_enable;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PACKER_HEADER_EN
  // Header sequencer and session counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q      <= HdrIdle;
      sess_cnt_q <= 8'h00;
    end else begin
      hdr_q      <= hdr_d;
      sess_cnt_q <= sess_cnt_d;
    end
  end
`endif

  // Storage array; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // FWFT outputs; data forced to zero while empty.
  always_comb begin
    out_valid  = (level_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    fifo_level = level_q;
    overflow   = overflow_q;
  end

endmodule

// File: doc/adpcm_nibble_packer.md
Name: adpcm_nibble_packer

Overview:
- Sits directly downstream of the CIC/ADPCM wrapper and consumes its 4-bit IMA ADPCM codes and valid signal.
- Packs consecutive codes into bytes, first code in the low nibble, per the IMA convention.
- Buffers the bytes in a first-word-fall-through (FWFT) FIFO.
- Presents a valid/ready byte stream to the host/serial interface stage.
- Tolerates a valid that stays high for many clk cycles, because the encoder runs on the derived slow_clk.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of 2 and at least 4.
- PAD_NIBBLE, 4'h0, code used to complete a half-filled byte on flush.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- block_enable, input, 1, session enable; same signal that drives the upstream wrapper.
- in_code, input, 4, ADPCM code from the encoder (encPcm).
- in_valid, input, 1, encoder outValid; a level that may last many clk cycles.
- out_data, output, 8, FIFO head byte.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, downstream accepts out_data this cycle.
- fifo_level, output, $clog2(DEPTH)+1, number of bytes stored.
- overflow, output, 1, sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous): all state is cleared.
  - Pointers, fifo_level, packer state, in_valid_d, en_d and overflow all go to 0.
  - out_valid is 0 and out_data is 8'h00.
- Input capture:
  - in_valid_d and en_d are registers holding in_valid and block_enable from the previous cycle.
  - accept = in_valid & ~in_valid_d & block_enable. Only the rising edge of in_valid is accepted; one code is taken per edge.
  - A held-high in_valid yields exactly one code.
- Packer states:
  - EMPTY: on accept, store in_code in lo_nib and go to HALF.
  - HALF: on accept, push byte {in_code, lo_nib} and return to EMPTY.
- Session start (block_enable & ~en_d):
  - Packer forced to EMPTY; overflow cleared.
  - FIFO contents are kept.
- Session end (~block_enable & en_d):
  - If the packer is in HALF, push {PAD_NIBBLE, lo_nib} and go to EMPTY.
  - An in_valid edge in the same cycle as block_enable falling is not accepted, since block_enable is already 0.
- FIFO:
  - FWFT: out_data = mem[rd_ptr], out_valid = (fifo_level != 0).
  - Pop when out_valid & out_ready.
  - A push is accepted when fifo_level < DEPTH, or when a pop happens in the same cycle. Simultaneous push and pop leaves fifo_level unchanged.
  - A push when full with no pop drops the byte, sets overflow, and leaves pointers unchanged.
  - Pointers wrap modulo DEPTH.
  - out_data is held while out_valid is high and out_ready is low.
- Latency: a push in cycle N makes the byte visible on out_data in cycle N+1. If the FIFO was empty, out_valid rises in N+1.
- Reset mid-session clears everything, including buffered bytes; nothing is flushed.
- At most one push source is active per cycle: data and flush are mutually exclusive by construction.

Optional Feature:
- Macro PACKER_HEADER_EN.
- When defined:
  - An 8-bit session counter sess_cnt is added; it resets to 0.
  - On session start, header byte 8'hA5 is pushed in the cycle after the rising edge, then sess_cnt in the following cycle.
  - sess_cnt then increments, wrapping from 255 to 0.
  - Header pushes follow the normal full/overflow rules.
  - No data push can occur before cycle +3 (two accepted edges are needed), so header and data never collide.
- When undefined: no header and no counter; the stream carries data bytes only.

Test Plan:
- Basic packing: enable, then four in_valid pulses with codes 3, A, 5, C, and out_ready held high. Required: bytes 8'hA3 then 8'hC5; each byte appears one cycle after the second accepted nibble; out_valid is low between bytes.
- Long valid: hold in_valid high for 20 cycles with in_code 7, then a second rising edge with code 1. Required: exactly one byte, 8'h17; fifo_level reaches 1.
- Flush: enable, one code 9, then block_enable falls. Required: byte 8'h09 with PAD_NIBBLE 0 is pushed in the falling-edge cycle; the packer returns to EMPTY.
- Overflow with DEPTH 16: out_ready low, push 17 bytes. Required: fifo_level is 16 and overflow is 1; draining yields the first 16 bytes in order; the 17th is dropped; the next block_enable rise clears overflow.
- Full with simultaneous pop: FIFO full, out_ready high in the cycle of a push. Required: push accepted, fifo_level stays 16, overflow stays 0.
- Reset: rst_n low mid-session with 5 bytes buffered and a half nibble pending. Required: immediately out_valid is 0, fifo_level is 0 and overflow is 0; no flush byte after release. With PACKER_HEADER_EN, the first two sessions emit A5 00 and A5 01.
